pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush/freeze sequencer for the 5-stage pipeline. Drives the IF/ID register

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM state
// encoding and the NOP instruction word loaded into IF/ID on a flush.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2,
        STEP     = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: EX-stage load whose destination feeds
// a source operand of the instruction currently in ID.
module hazard_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    output logic             load_use
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit   = id_uses_rs && (id_rs == ex_rd);
        rt_hit   = id_uses_rt && (id_rt == ex_rd);
        // Register 0 is hardwired, so a load targeting it never creates a dependency.
        load_use = ex_mem_read && (ex_rd != '0) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline (load-use, branch
// flush, data-memory wait with timeout, debug halt/step).
// Optional macro PIPE_CTRL_PERF_EN adds saturating performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_branch_taken,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             dbg_halt,
    input  logic             dbg_step,
    output logic             cpu_en,
    output logic             pc_write,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt,
    output logic [31:0]      perf_freeze_cnt,
`endif
    output logic             bus_err
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
    logic             bus_err_nx;
    logic             load_use;
    logic             advance;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            bus_err  <= bus_err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        bus_err_nx  = bus_err;
        advance     = 1'b0;
        cpu_en      = 1'b0;
        pc_write    = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;

        unique case (state)
            RUN, STEP: begin
                // The freezing cycle itself counts toward the timeout budget.
                if (mem_req && !dmem_ready) begin
                    state_nx    = MEM_WAIT;
                    wait_cnt_nx = CNT_W'(1);
                end else begin
                    advance = 1'b1;
                    if (state == STEP || dbg_halt) state_nx = HALT;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    advance     = 1'b1;
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                    bus_err_nx  = 1'b1;
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else begin
                    wait_cnt_nx = wait_cnt + CNT_W'(1);
                end
            end
            HALT: begin
                halted = 1'b1;
                if (dbg_step)       state_nx = STEP;
                else if (!dbg_halt) state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase

        // Load-use stall outranks the branch flush; the branch re-resolves next cycle.
        if (advance) begin
            cpu_en = 1'b1;
            if (load_use) begin
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_flush = id_branch_taken;
            end
        end

        if (!rst_n) begin
            cpu_en      = 1'b0;
            pc_write    = 1'b0;
            ifid_hold   = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            halted      = 1'b0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt  <= '0;
            perf_flush_cnt  <= '0;
            perf_freeze_cnt <= '0;
        end else begin
            if (idex_bubble && perf_stall_cnt != '1)  perf_stall_cnt  <= perf_stall_cnt + 32'd1;
            if (ifid_flush && perf_flush_cnt != '1)   perf_flush_cnt  <= perf_flush_cnt + 32'd1;
            if (!cpu_en && perf_freeze_cnt != '1)     perf_freeze_cnt <= perf_freeze_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard/memory/debug
// scenarios followed by randomized traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int          TMO   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_uses_rs, id_uses_rt, id_branch_taken, ex_mem_read;
    logic             mem_req, dmem_ready, dbg_halt, dbg_step;
    logic             cpu_en, pc_write, ifid_hold, ifid_flush, idex_bubble, halted, bus_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]      perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt;
`endif

    pipeline_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_branch_taken (id_branch_taken),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .dbg_halt        (dbg_halt),
        .dbg_step        (dbg_step),
        .cpu_en          (cpu_en),
        .pc_write        (pc_write),
        .ifid_hold       (ifid_hold),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .halted          (halted),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt),
        .perf_freeze_cnt (perf_freeze_cnt),
`endif
        .bus_err         (bus_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: debug mode flags, whether a memory access is outstanding,
    // and how many frozen cycles that access has consumed so far.
    bit m_halted, m_stepping, m_in_wait, m_bus_err;
    int m_frozen;
    int kind;  // 0 = debug frozen, 1 = memory frozen, 2 = pipeline advances
    logic e_cpu_en, e_pc_write, e_hold, e_flush, e_bubble, e_halted, e_bus_err;
    logic last_cpu_en;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_halted   = 1'b0;
        m_stepping = 1'b0;
        m_in_wait  = 1'b0;
        m_bus_err  = 1'b0;
        m_frozen   = 0;
    endtask

    task automatic model_eval();
        bit lu;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        {e_cpu_en, e_pc_write, e_hold, e_flush, e_bubble} = '0;
        e_halted  = m_halted && !m_stepping;
        e_bus_err = m_bus_err;
        if (m_halted && !m_stepping)                 kind = 0;
        else if ((m_in_wait || mem_req) && !dmem_ready) kind = 1;
        else begin
            kind     = 2;
            e_cpu_en = 1'b1;
            if (lu) begin
                e_hold   = 1'b1;
                e_bubble = 1'b1;
            end else begin
                e_pc_write = 1'b1;
                e_flush    = id_branch_taken;
            end
        end
    endtask

    task automatic model_commit();
        bit was_wait;
        case (kind)
            0: begin
                if (dbg_step)       m_stepping = 1'b1;
                else if (!dbg_halt) m_halted   = 1'b0;
            end
            1: begin
                if (m_stepping) begin
                    m_stepping = 1'b0;
                    m_halted   = 1'b0;
                end
                m_in_wait = 1'b1;
                m_frozen++;
                if (m_frozen == TMO + 1) begin
                    m_bus_err = 1'b1;
                    m_in_wait = 1'b0;
                    m_frozen  = 0;
                end
            end
            default: begin
                was_wait  = m_in_wait;
                m_in_wait = 1'b0;
                m_frozen  = 0;
                if (m_stepping)                 m_stepping = 1'b0;
                else if (!was_wait && dbg_halt) m_halted   = 1'b1;
            end
        endcase
    endtask

    // Entered at posedge+1 with inputs applied; samples at the falling edge.
    task automatic run_cycle(input string tag);
        model_eval();
        #4;
        last_cpu_en = cpu_en;
        chk({tag, ".cpu_en"},   cpu_en,      e_cpu_en);
        chk({tag, ".pc_write"}, pc_write,    e_pc_write);
        chk({tag, ".hold"},     ifid_hold,   e_hold);
        chk({tag, ".flush"},    ifid_flush,  e_flush);
        chk({tag, ".bubble"},   idex_bubble, e_bubble);
        chk({tag, ".halted"},   halted,      e_halted);
        chk({tag, ".bus_err"},  bus_err,     e_bus_err);
        chk({tag, ".excl"},     ifid_hold & ifid_flush, 1'b0);
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".cpu_en"},   cpu_en,      1'b0);
        chk({tag, ".pc_write"}, pc_write,    1'b0);
        chk({tag, ".hold"},     ifid_hold,   1'b0);
        chk({tag, ".flush"},    ifid_flush,  1'b0);
        chk({tag, ".bubble"},   idex_bubble, 1'b0);
        chk({tag, ".halted"},   halted,      1'b0);
        chk({tag, ".bus_err"},  bus_err,     1'b0);
    endtask

    task automatic clear_in();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_branch_taken = 1'b0;
        ex_mem_read = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
        dbg_halt = 1'b0; dbg_step = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ones;
        rst_n = 1'b0;
        clear_in();
        model_reset();
        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_cycle("idle");

        // Load-use via rs, then clear
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        run_cycle("lu_rs");
        clear_in();
        run_cycle("after_lu");

        // Same compare with ex_rd = 0: no stall
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        run_cycle("lu_r0");
        clear_in();

        id_branch_taken = 1'b1;
        run_cycle("branch");
        clear_in();

        // Load-use and branch together: stall wins
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_branch_taken = 1'b1;
        run_cycle("lu_br");
        ex_mem_read = 1'b0;
        run_cycle("br_retry");
        clear_in();

        // Matching reg but operand not used: no stall
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b0;
        run_cycle("lu_unused");
        clear_in();

        // Memory wait: ready low 3 cycles, then high
        mem_req = 1'b1;
        ones = 0;
        for (int i = 0; i < 3; i++) begin
            run_cycle("mwait");
            ones += int'(last_cpu_en);
        end
        chk_int("mwait_frozen_en", ones, 0);
        dmem_ready = 1'b1;
        run_cycle("mready");
        clear_in();
        run_cycle("post_mem");

        // Timeout: never ready
        mem_req = 1'b1;
        for (int i = 0; i < TMO + 1; i++) run_cycle("tmo");
        clear_in();
        chk("tmo_bus_err", bus_err, 1'b1);
        run_cycle("post_tmo");

        // Debug halt and two single steps
        dbg_halt = 1'b1;
        run_cycle("halt_req");
        chk("halted_next", halted, 1'b1);
        ones = 0;
        for (int i = 0; i < 6; i++) begin
            dbg_step = (i == 1 || i == 3);
            run_cycle("halt_step");
            ones += int'(last_cpu_en);
        end
        chk_int("step_cycles", ones, 2);
        dbg_step = 1'b0;
        dbg_halt = 1'b0;
        run_cycle("release");
        run_cycle("resumed");

        // Step while running is ignored
        dbg_step = 1'b1;
        run_cycle("step_run");
        clear_in();
        run_cycle("step_run2");

        // Reset during MEM_WAIT (bus_err is currently set)
        mem_req = 1'b1;
        run_cycle("pre_rst0");
        run_cycle("pre_rst1");
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_in();
        run_cycle("after_rst");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            id_rs           = REG_W'($urandom_range(0, 3));
            id_rt           = REG_W'($urandom_range(0, 3));
            ex_rd           = REG_W'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_branch_taken = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            mem_req         = ($urandom_range(0, 3) == 0);
            dmem_ready      = 1'($urandom_range(0, 1));
            run_cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
